// File: rtl/mips_io_pkg.sv
// Shared definitions for the Mini-MIPS board I/O conditioning path:
// press-handling states and the instruction field positions on sw[15:0].
package mips_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PENDING      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_e;

    localparam int DISP_UPPER_BIT = 15;
    localparam int OPC_ST_BIT     = 14;
    localparam int RD_HI          = 13;
    localparam int RD_LO          = 10;
    localparam int RS_HI          = 9;
    localparam int RS_LO          = 6;
    localparam int OFF_HI         = 5;
    localparam int OFF_LO         = 0;

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus counter debouncer for one raw push-button.
// Ports: clk, reset (sync, active-high), btn_raw (async in),
//        btn_level (debounced level out).
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level
);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The level flips on the mismatch after the counter has already
    // counted DEBOUNCE_CYCLES of them, so DEBOUNCE_CYCLES+1 agreeing
    // synchronised samples are needed.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/exec_input_conditioner.sv
// Board-pin conditioner for the Mini-MIPS core: debounced execute button,
// switch-word capture and a single-cycle issue strobe per physical press.
// Ports: clk, reset (sync, active-high), execute_btn, sw[15:0], core_busy in;
//        exec_pulse, instr[15:0], btn_level, disp_upper, disp_reg[3:0],
//        press_count[7:0] out.
module exec_input_conditioner
    import mips_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        execute_btn,
    input  logic [15:0] sw,
    input  logic        core_busy,
    output logic        exec_pulse,
    output logic [15:0] instr,
    output logic        btn_level,
    output logic        disp_upper,
    output logic [3:0]  disp_reg,
    output logic [7:0]  press_count
);

    // After reset the debouncer needs DEBOUNCE_CYCLES+3 edges before a
    // held button can show up on btn_level; leaving WAIT_RELEASE earlier
    // would let a button held through reset fire.
    localparam int SETTLE   = DEBOUNCE_CYCLES + 4;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic [15:0]         sw_meta_q;
    logic [15:0]         sw_sync_q;
    logic                btn_level_w;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] settle_d;
    logic                settled;
    state_e              state_q;
    logic                exec_pulse_q;
    logic [15:0]         instr_q;
    logic [7:0]          press_count_q;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (execute_btn),
        .btn_level (btn_level_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign settled = (settle_q == SETTLE_W'(SETTLE));

    always_comb begin
        settle_d = settle_q;
        if (!settled) begin
            settle_d = settle_q + SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_d;
        end
    end

    // IDLE is only entered with btn_level low, so btn_level high while
    // in IDLE is exactly a fresh 0->1 event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT_RELEASE;
            exec_pulse_q  <= 1'b0;
            instr_q       <= '0;
            press_count_q <= '0;
        end else begin
            exec_pulse_q <= 1'b0;
            unique case (state_q)
                ST_WAIT_RELEASE: begin
                    if (settled && !btn_level_w) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (btn_level_w) begin
                        instr_q <= sw_sync_q;
                        if (!core_busy) begin
                            exec_pulse_q  <= 1'b1;
                            press_count_q <= press_count_q + 8'd1;
                            state_q       <= ST_WAIT_RELEASE;
                        end else begin
                            state_q <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!core_busy) begin
                        exec_pulse_q  <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                        state_q       <= ST_WAIT_RELEASE;
                    end
                end
                default: begin
                    state_q <= ST_WAIT_RELEASE;
                end
            endcase
        end
    end

    assign exec_pulse  = exec_pulse_q;
    assign instr       = instr_q;
    assign btn_level   = btn_level_w;
    assign disp_upper  = sw_sync_q[DISP_UPPER_BIT];
    assign disp_reg    = sw_sync_q[RD_HI:RD_LO];
    assign press_count = press_count_q;

endmodule

// File: tb/tb_exec_input_conditioner.sv
// Self-checking bench for exec_input_conditioner: directed scenarios plus
// a randomized phase, all compared against a behavioural press model.
module tb_exec_input_conditioner;

    localparam int D      = 2;
    localparam int SETTLE = D + 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        execute_btn;
    logic [15:0] sw;
    logic        core_busy;
    logic        exec_pulse;
    logic [15:0] instr;
    logic        btn_level;
    logic        disp_upper;
    logic [3:0]  disp_reg;
    logic [7:0]  press_count;

    exec_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .execute_btn (execute_btn),
        .sw          (sw),
        .core_busy   (core_busy),
        .exec_pulse  (exec_pulse),
        .instr       (instr),
        .btn_level   (btn_level),
        .disp_upper  (disp_upper),
        .disp_reg    (disp_reg),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int npulse = 0;

    // Behavioural model state
    bit          m_lvl, m_lvl_prev, m_wait, m_pend, m_pulse;
    int          m_run, m_age;
    logic [15:0] m_instr;
    logic [7:0]  m_count;
    bit          bh [2];
    logic [15:0] swh [2];

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue();
        m_pulse = 1'b1;
        m_count = m_count + 8'd1;
        m_pend  = 1'b0;
        m_wait  = 1'b1;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit          s, lvl_old, rise;
        logic [15:0] sws;
        if (reset) begin
            m_lvl = 0; m_lvl_prev = 0; m_run = 0; m_age = 0;
            m_wait = 1; m_pend = 0; m_pulse = 0;
            m_instr = '0; m_count = '0;
            bh[0] = 0; bh[1] = 0; swh[0] = '0; swh[1] = '0;
            return;
        end
        s       = bh[1];
        sws     = swh[1];
        lvl_old = m_lvl;
        rise    = lvl_old && !m_lvl_prev;
        m_pulse = 1'b0;
        if (m_wait) begin
            if (!lvl_old && m_age >= SETTLE) m_wait = 1'b0;
        end else if (m_pend) begin
            if (!core_busy) issue();
        end else if (rise) begin
            m_instr = sws;
            if (!core_busy) issue();
            else m_pend = 1'b1;
        end
        if (s != m_lvl) begin
            m_run++;
            if (m_run > D) begin
                m_lvl = !m_lvl;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_lvl_prev = lvl_old;
        bh[1]  = bh[0];
        bh[0]  = execute_btn;
        swh[1] = swh[0];
        swh[0] = sw;
        if (m_age < SETTLE) m_age++;
    endtask

    task automatic check_all();
        chk("exec_pulse", 16'(exec_pulse), 16'(m_pulse));
        chk("instr", instr, m_instr);
        chk("btn_level", 16'(btn_level), 16'(m_lvl));
        chk("disp_upper", 16'(disp_upper), 16'(swh[1][15]));
        chk("disp_reg", 16'(disp_reg), 16'(swh[1][13:10]));
        chk("press_count", 16'(press_count), 16'(m_count));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            if (exec_pulse === 1'b1) npulse++;
            check_all();
        end
    endtask

    task automatic press(input int hi, input int lo);
        execute_btn = 1'b1;
        step(hi);
        execute_btn = 1'b0;
        step(lo);
    endtask

    int p0;
    int lat;
    int run_left;
    logic [7:0] c0;

    initial begin
        reset = 1'b1; execute_btn = 1'b0;
        sw = 16'h1803; core_busy = 1'b0;
        step(3);

        // Reset state and live display fields
        reset = 1'b0;
        chk("rst_pulse", 16'(exec_pulse), 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_count", 16'(press_count), 16'd0);
        step(2);
        chk("disp_reg_2cyc", 16'(disp_reg), 16'd6);
        chk("disp_upper_2cyc", 16'(disp_upper), 16'd0);
        p0 = npulse;
        step(10);
        chk("no_pulse_idle", 16'(npulse - p0), 16'd0);

        // Clean press: latency and capture
        sw = 16'b0_0_0110_0000_000011;
        p0 = npulse;
        lat = 0;
        execute_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) execute_btn = 1'b0;
            step(1);
            if (exec_pulse === 1'b1 && lat == 0) lat = i;
        end
        chk("press_latency", 16'(lat), 16'(D + 4));
        chk("press_pulses", 16'(npulse - p0), 16'd1);
        chk("press_instr", instr, 16'h1803);
        chk("press_count1", 16'(press_count), 16'd1);

        // Short glitch is filtered
        p0 = npulse;
        press(2, 10);
        chk("glitch_level", 16'(btn_level), 16'd0);
        chk("glitch_pulses", 16'(npulse - p0), 16'd0);
        chk("glitch_count", 16'(press_count), 16'd1);

        // Press while busy, then sw change and release while pending
        core_busy = 1'b1;
        sw = 16'hA5C3;
        p0 = npulse;
        execute_btn = 1'b1;
        step(5);
        sw = 16'hFFFF;
        step(5);
        execute_btn = 1'b0;
        step(5);
        chk("busy_no_pulse", 16'(npulse - p0), 16'd0);
        core_busy = 1'b0;
        step(1);
        chk("busy_drop_pulse", 16'(exec_pulse), 16'd1);
        chk("busy_instr", instr, 16'hA5C3);
        step(8);
        chk("busy_pulses", 16'(npulse - p0), 16'd1);
        chk("busy_count", 16'(press_count), 16'd2);

        // Button held through reset never fires
        execute_btn = 1'b1;
        step(8);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        p0 = npulse;
        step(20);
        chk("held_rst_pulses", 16'(npulse - p0), 16'd0);
        execute_btn = 1'b0;
        step(8);
        chk("held_rel_pulses", 16'(npulse - p0), 16'd0);
        press(4, 8);
        chk("after_rel_pulses", 16'(npulse - p0), 16'd1);

        // 256 presses wrap the counter
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        for (int k = 0; k < 256; k++) begin
            sw = 16'($urandom);
            p0 = npulse;
            press(4, 6);
            chk("wrap_one_pulse", 16'(npulse - p0), 16'd1);
        end
        chk("wrap_count", 16'(press_count), 16'd0);

        // Randomized traffic against the model
        c0 = press_count;
        run_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_left == 0) begin
                execute_btn = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 7);
            end
            run_left--;
            core_busy = ($urandom_range(0, 3) == 0);
            sw = 16'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        execute_btn = 1'b0;
        core_busy = 1'b0;
        step(12);
        chk("rand_final_count", 16'(press_count), 16'(m_count));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
